sme_char_feeder: RTL and testbench
==================================

// Module: sme_char_feeder
// PURPOSE
//   Upstream stage of the string-matching engine. Accepts framed records (string or pattern) from a
//   valid/ready byte stream, buffers one record, then replays it to the matcher as a gap-free burst
//   on chardata with isstring/ispattern qualifiers. Holds off the next record after a pattern until
//   the matcher pulses its result valid.
// PARAMETERS
//   MAX_LEN  32    max chars per record stored; extra chars dropped
//   LEN_W    6     width of length/index counters (holds 0..MAX_LEN)
//   TIMEOUT  1024  result-wait watchdog limit in cycles (only with SME_FEED_TIMEOUT_EN)
// PORTS
//   clk          in   1  clock
//   reset        in   1  asynchronous, active-high reset
//   in_valid     in   1  upstream byte valid
//   in_ready     out  1  feeder can accept byte
//   in_data      in   8  record character (ASCII; pattern meta chars ^ $ . * passed verbatim)
//   in_kind      in   1  0=string record, 1=pattern record; sampled on first byte only
//   in_last      in   1  marks final byte of record
//   chardata     out  8  character to matcher
//   isstring     out  1  chardata is a string char
//   ispattern    out  1  chardata is a pattern char
//   sme_valid    in   1  matcher result-valid pulse
//   busy         out  1  state != IDLE
//   ovf_err      out  1  sticky: a record exceeded MAX_LEN
//   tmo_err      out  1  sticky: watchdog fired (0 when macro off)
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=0 then 1 from first clock after release; chardata=8'h00;
//     isstring=ispattern=0; busy=0; ovf_err=tmo_err=0; len=idx=0; buffer contents don't-care.
//   States: IDLE, LOAD, SEND, WAIT_RES.
//   IDLE: in_ready=1. Accepted byte (in_valid&in_ready) -> buf[0]=in_data, kind=in_kind, len=1;
//     in_last=1 -> SEND, else LOAD.
//   LOAD: in_ready=1. Each accepted byte written to buf[len], len++ while len<MAX_LEN; when
//     len==MAX_LEN byte is dropped and ovf_err set. in_last accepted -> SEND.
//   SEND: in_ready=0. Registered outputs: one char per cycle, buf[0..len-1], idx 0..len-1, no gaps;
//     isstring=~kind, ispattern=kind, both high exactly len consecutive cycles, never both high.
//     First char appears the cycle after SEND entered. After idx==len-1 emitted: kind=0 -> IDLE;
//     kind=1 -> WAIT_RES. Qualifiers drop to 0 the cycle after the last char; chardata -> 8'h00.
//   WAIT_RES: in_ready=0, qualifiers 0. sme_valid=1 -> IDLE next cycle.
//   sme_valid in any state other than WAIT_RES ignored.
//   Guaranteed: >=1 idle cycle (qualifiers low) between consecutive bursts, since IDLE always
//     precedes a new accept and a new SEND.
//   Latency: last byte accepted at cycle T -> first char on chardata at T+2; record of N chars
//     occupies chardata T+2..T+N+1.
//   Back-pressure: in_ready combinational from state only (not from in_valid).
//   in_valid low mid-record in LOAD: wait indefinitely, no timeout.
//   Reset mid-SEND or mid-WAIT_RES: outputs cleared immediately (async), partial record discarded.
//   Counter width: len/idx LEN_W bits, saturate at MAX_LEN, never wrap.
// CONFIGURATION
//   SME_FEED_TIMEOUT_EN defined: counter cleared on WAIT_RES entry, increments each WAIT_RES cycle;
//     reaching TIMEOUT-1 without sme_valid -> tmo_err set (sticky), state -> IDLE next cycle.
//   Not defined: no counter, WAIT_RES waits forever, tmo_err tied 0.
// TESTING
//   String "abc" (kind0, last on 'c') -> isstring high 3 cycles, chardata 61,62,63; then IDLE, busy=0.
//   String "ab" then pattern "^b*" -> 2 isstring chars, >=1 gap, 3 ispattern chars 5E,62,2A;
//     in_ready=0 until sme_valid pulse, 1 the cycle after.
//   40-char string -> first 32 chars emitted (isstring high 32 cycles), ovf_err=1 and stays 1.
//   Reset asserted on 2nd char of a 5-char SEND -> isstring=0, chardata=00 same cycle; next record
//     after release sends cleanly from buf[0].
//   Macro on, TIMEOUT=16, pattern sent, sme_valid never -> tmo_err=1 after 16 WAIT_RES cycles,
//     in_ready=1 next cycle; macro off -> busy stays 1.

Source files
------------

// File: rtl/sme_char_feeder.sv
// -----------------------------------------------------------------------------
// sme_char_feeder
//
// Upstream stage of the string-matching engine. Collects one framed record
// (string or pattern) from a valid/ready byte stream into a local buffer, then
// replays it to the matcher as a gap-free burst on chardata, qualified by
// isstring / ispattern. After a pattern burst the feeder holds off new input
// until the matcher pulses sme_valid.
//
// Parameters
//   MAX_LEN   max characters stored per record; extra characters are dropped
//   LEN_W     width of the length/index counters (must hold 0..MAX_LEN)
//   TIMEOUT   result-wait watchdog limit in cycles (SME_FEED_TIMEOUT_EN only)
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   upstream byte valid
//   in_ready   out  feeder can accept a byte (depends on state only)
//   in_data    in   record character, meta chars passed verbatim
//   in_kind    in   0 = string record, 1 = pattern record (first byte only)
//   in_last    in   final byte of the record
//   chardata   out  character to matcher (8'h00 when no qualifier is high)
//   isstring   out  chardata is a string character
//   ispattern  out  chardata is a pattern character
//   sme_valid  in   matcher result-valid pulse
//   busy       out  feeder is not idle
//   ovf_err    out  sticky: a record was longer than MAX_LEN
//   tmo_err    out  sticky: result-wait watchdog fired
//
// Build option
//   `define SME_FEED_TIMEOUT_EN to enable the result-wait watchdog. Without
//   it WAIT_RES waits forever and tmo_err is constant 0.
// -----------------------------------------------------------------------------
module sme_char_feeder #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    output logic       busy,
    output logic       ovf_err,
    output logic       tmo_err
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_SEND     = 2'd2;
    localparam logic [1:0] ST_WAIT_RES = 2'd3;

    localparam int               ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    logic [1:0]       state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] idx_reg, idx_next;
    logic             kind_reg, kind_next;
    logic             ovf_reg, ovf_next;
    logic             tmo_reg, tmo_next;
    logic             isstring_reg, isstring_next;
    logic             ispattern_reg, ispattern_next;
    logic             ready_en_reg;

    // Record buffer: plain array, write port from the input side, registered
    // read port feeding chardata. No reset so it maps onto block RAM.
    logic [7:0]        char_mem [0:MAX_LEN-1];
    logic [7:0]        rd_data_reg;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    logic accept;
    logic last_char;
    logic tmo_expire;

    // in_ready stays low while reset is held and for the partial cycle after
    // release; it rises on the first clock edge after reset deasserts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    assign in_ready  = ready_en_reg && ((state_reg == ST_IDLE) || (state_reg == ST_LOAD));
    assign accept    = in_valid && in_ready;
    assign busy      = (state_reg != ST_IDLE);
    assign last_char = (idx_reg == (len_reg - ONE_L));
    assign rd_addr   = idx_reg[ADDR_W-1:0];

    // -------------------------------------------------------------------------
    // Result-wait watchdog
    // -------------------------------------------------------------------------
`ifdef SME_FEED_TIMEOUT_EN
    localparam int               TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_reg;

    // Held at zero outside WAIT_RES so every WAIT_RES entry starts from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg != ST_WAIT_RES) begin
            tmo_cnt_reg <= '0;
        end else if (tmo_cnt_reg != TMO_LAST) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

    // A result arriving in the same cycle as expiry wins; no error then.
    assign tmo_expire = (state_reg == ST_WAIT_RES) && !sme_valid && (tmo_cnt_reg == TMO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign tmo_expire     = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        idx_next       = idx_reg;
        kind_next      = kind_reg;
        ovf_next       = ovf_reg;
        tmo_next       = tmo_reg | tmo_expire;
        isstring_next  = 1'b0;
        ispattern_next = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = '0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    kind_next  = in_kind;
                    len_next   = ONE_L;
                    idx_next   = '0;
                    state_next = in_last ? ST_SEND : ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    // Bytes past MAX_LEN are dropped but the frame is still
                    // consumed so in_last is honoured.
                    if (len_reg < MAX_LEN_L) begin
                        wr_en    = 1'b1;
                        wr_addr  = len_reg[ADDR_W-1:0];
                        len_next = len_reg + ONE_L;
                    end else begin
                        ovf_next = 1'b1;
                    end
                    if (in_last) begin
                        state_next = ST_SEND;
                    end
                end
            end

            ST_SEND: begin
                // Qualifiers are registered alongside the RAM read data, so
                // the character addressed by idx appears one cycle later.
                isstring_next  = ~kind_reg;
                ispattern_next = kind_reg;
                if (last_char) begin
                    idx_next   = '0;
                    state_next = kind_reg ? ST_WAIT_RES : ST_IDLE;
                end else begin
                    idx_next = idx_reg + ONE_L;
                end
            end

            ST_WAIT_RES: begin
                if (sme_valid || tmo_expire) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            idx_reg       <= '0;
            kind_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            tmo_reg       <= 1'b0;
            isstring_reg  <= 1'b0;
            ispattern_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            idx_reg       <= idx_next;
            kind_reg      <= kind_next;
            ovf_reg       <= ovf_next;
            tmo_reg       <= tmo_next;
            isstring_reg  <= isstring_next;
            ispattern_reg <= ispattern_next;
        end
    end

    // -------------------------------------------------------------------------
    // Record buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            char_mem[wr_addr] <= in_data;
        end
        rd_data_reg <= char_mem[rd_addr];
    end

    // The RAM output register has no reset; gating with the qualifiers forces
    // chardata to 00 between bursts and immediately on reset.
    assign chardata  = (isstring_reg || ispattern_reg) ? rd_data_reg : 8'h00;
    assign isstring  = isstring_reg;
    assign ispattern = ispattern_reg;
    assign ovf_err   = ovf_reg;
    assign tmo_err   = tmo_reg;

endmodule

// File: tb/tb_sme_char_feeder.sv
// -----------------------------------------------------------------------------
// tb_sme_char_feeder
//
// Self-checking bench for sme_char_feeder. Records are pushed as bytes; the
// expected burst characters go into a queue and a monitor pops and compares
// them as the DUT emits them. Define SME_FEED_TIMEOUT_EN for both the DUT and
// the bench to exercise the watchdog build.
// -----------------------------------------------------------------------------
module tb_sme_char_feeder;

    localparam int MAX_LEN = 32;
    localparam int TMO     = 16;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_kind;
    logic       in_last;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid;
    logic       busy;
    logic       ovf_err;
    logic       tmo_err;

    sme_char_feeder #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (6),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_kind   (in_kind),
        .in_last   (in_last),
        .chardata  (chardata),
        .isstring  (isstring),
        .ispattern (ispattern),
        .sme_valid (sme_valid),
        .busy      (busy),
        .ovf_err   (ovf_err),
        .tmo_err   (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ch;
        logic       kind;
        logic       first;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: compares every emitted character against the scoreboard.
    initial begin : monitor
        logic prev_q;
        logic cur_q;
        exp_t e;
        prev_q = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_q = 1'b0;
            end else begin
                cur_q = isstring | ispattern;
                if (isstring && ispattern) check_val("both_qual", 32'(ispattern), 32'd0);
                if (cur_q) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_char", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("chardata", 32'(chardata), 32'(e.ch));
                        check_val("ispattern", 32'(ispattern), 32'(e.kind));
                        if (e.first) check_val("burst_gap", 32'(prev_q), 32'd0);
                        else         check_val("burst_contig", 32'(prev_q), 32'd1);
                    end
                end else begin
                    check_val("idle_chardata", 32'(chardata), 32'd0);
                end
                prev_q = cur_q;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic k, input logic l);
        int waitc;
        waitc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_kind  = k;
        in_last  = l;
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        check_val("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends a record; in_kind is inverted after the first byte to prove it is
    // only sampled once. Returns at the negedge where the first char shows.
    task automatic send_rec(input logic [7:0] chars[$], input logic kind);
        int n;
        n = chars.size();
        $display("record kind=%0d len=%0d", kind, n);
        for (int i = 0; i < n; i++) begin
            if (i < MAX_LEN) begin
                exp_q.push_back({chars[i], kind, (i == 0)});
            end
            send_byte(chars[i], (i == 0) ? kind : ~kind, (i == n - 1));
        end
        @(negedge clk);
        check_val("lat_t1_qual", 32'(isstring | ispattern), 32'd0);
        @(negedge clk);
        check_val("lat_t2_qual", 32'(kind ? ispattern : isstring), 32'd1);
    endtask

    task automatic send_str(input string s, input logic kind);
        logic [7:0] q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        send_rec(q, kind);
    endtask

    task automatic drain(input string tag);
        int waitc;
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        @(negedge clk);
        @(negedge clk);
        check_val(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_result();
        @(negedge clk);
        sme_valid = 1'b1;
        @(posedge clk);
        #1;
        sme_valid = 1'b0;
    endtask

    initial begin : stimulus
        logic [7:0] long_q[$];

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_kind   = 1'b0;
        in_last   = 1'b0;
        sme_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_chardata", 32'(chardata), 32'd0);
        check_val("rst_isstring", 32'(isstring), 32'd0);
        check_val("rst_ispattern", 32'(ispattern), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ovf", 32'(ovf_err), 32'd0);
        check_val("rst_tmo", 32'(tmo_err), 32'd0);
        reset = 1'b0;
        #1;
        check_val("rel_in_ready_lo", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_val("rel_in_ready_hi", 32'(in_ready), 32'd1);

        // Plain string
        send_str("abc", 1'b0);
        drain("drain_abc");
        check_val("abc_busy", 32'(busy), 32'd0);
        check_val("abc_in_ready", 32'(in_ready), 32'd1);

        // String then pattern, pattern holds off input until result
        send_str("ab", 1'b0);
        send_str("^b*", 1'b1);
        drain("drain_pat");
        repeat (3) @(negedge clk);
        check_val("wait_in_ready", 32'(in_ready), 32'd0);
        check_val("wait_busy", 32'(busy), 32'd1);
        pulse_result();
        @(negedge clk);
        check_val("res_in_ready", 32'(in_ready), 32'd1);
        check_val("res_busy", 32'(busy), 32'd0);

        // sme_valid outside WAIT_RES is ignored
        pulse_result();
        @(negedge clk);
        check_val("stray_res_busy", 32'(busy), 32'd0);
        check_val("stray_res_ready", 32'(in_ready), 32'd1);

        // Over-length record: first MAX_LEN chars only, sticky overflow
        for (int i = 0; i < 40; i++) long_q.push_back(8'(8'h30 + i));
        send_rec(long_q, 1'b0);
        drain("drain_long");
        check_val("ovf_set", 32'(ovf_err), 32'd1);
        send_str("ok", 1'b0);
        drain("drain_ok");
        check_val("ovf_sticky", 32'(ovf_err), 32'd1);

        // Asynchronous reset in the middle of a burst
        send_str("hello", 1'b0);
        @(negedge clk);
        check_val("pre_rst_char", 32'(chardata), 32'h65);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_isstring", 32'(isstring), 32'd0);
        check_val("mid_rst_chardata", 32'(chardata), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_ovf", 32'(ovf_err), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", 32'(in_ready), 32'd1);
        send_str("xyz", 1'b0);
        drain("drain_xyz");

        // Pattern with no result: watchdog or indefinite wait
        send_str("a.", 1'b1);
        repeat (16) @(negedge clk);
        check_val("tmo_pre_ready", 32'(in_ready), 32'd0);
        check_val("tmo_pre_err", 32'(tmo_err), 32'd0);
        @(negedge clk);
`ifdef SME_FEED_TIMEOUT_EN
        check_val("tmo_err_set", 32'(tmo_err), 32'd1);
        check_val("tmo_ready", 32'(in_ready), 32'd1);
        check_val("tmo_busy", 32'(busy), 32'd0);
`else
        repeat (30) @(negedge clk);
        check_val("notmo_busy", 32'(busy), 32'd1);
        check_val("notmo_err", 32'(tmo_err), 32'd0);
        check_val("notmo_ready", 32'(in_ready), 32'd0);
        pulse_result();
        @(negedge clk);
        check_val("notmo_release", 32'(busy), 32'd0);
`endif
        check_val("final_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
